// File: rtl/dreg_serial_loader.sv
// Serial-to-parallel front end for the D register: start bit + WIDTH data bits, one-cycle en.
// Optional even-parity check is enabled by defining PARITY_CHECK_EN.
`timescale 1ns/1ps

module dreg_serial_loader #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             sin_valid,
    input  logic             sin_bit,
    output logic [WIDTH-1:0] D_out,
    output logic             en,
    output logic             busy,
    output logic             abort,
    output logic             par_err
);

`ifdef PARITY_CHECK_EN
    localparam int unsigned NumBits = WIDTH + 1;
`else
    localparam int unsigned NumBits = WIDTH;
`endif
    localparam int unsigned CntW = $clog2(WIDTH + 2);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(NumBits - 1);
    localparam logic [CntW-1:0] DataCnt = CntW'(WIDTH);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
    localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sr_q;
    logic [WIDTH-1:0]  sr_shift;
    logic [WIDTH-1:0]  word;
    logic [WIDTH-1:0]  d_q;
    logic [CntW-1:0]   bit_cnt_q;
    logic [TmoW-1:0]   tmo_cnt_q;
    logic              abort_q;
    logic              start;
    logic              last_bit;
    logic              tmo_hit;
    logic              frame_ok;

    always_comb begin
        start    = (state_q == StIdle) && sin_valid && !sin_bit;
        last_bit = (state_q == StShift) && sin_valid && (bit_cnt_q == LastCnt);
        // The TIMEOUT-th consecutive empty cycle is the one that aborts.
        tmo_hit  = (state_q == StShift) && !sin_valid && (tmo_cnt_q >= TmoLast);
    end

    always_comb begin
        if (MSB_FIRST != 0) begin
            sr_shift = (sr_q << 1) | WIDTH'(sin_bit);
        end else begin
            sr_shift = (sr_q >> 1) | (WIDTH'(sin_bit) << (WIDTH - 1));
        end
    end

`ifdef PARITY_CHECK_EN
    logic par_q;
    logic par_err_q;

    // Final bit is the parity bit, so the data word is already complete in sr_q.
    always_comb begin
        frame_ok = ~(par_q ^ sin_bit);
        word     = sr_q;
        par_err  = par_err_q;
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= last_bit && !frame_ok;
            if (start) begin
                par_q <= 1'b0;
            end else if ((state_q == StShift) && sin_valid && (bit_cnt_q < DataCnt)) begin
                par_q <= par_q ^ sin_bit;
            end
        end
    end
`else
    always_comb begin
        frame_ok = 1'b1;
        word     = sr_shift;
        par_err  = 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (last_bit) begin
                    state_d = frame_ok ? StLoad : StIdle;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                end
            end
            StLoad:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are all decoded from registers.
    always_comb begin
        en    = (state_q == StLoad);
        busy  = (state_q != StIdle);
        abort = abort_q;
        D_out = d_q;
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            sr_q      <= '0;
            d_q       <= '0;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            abort_q <= tmo_hit;
            if (start) begin
                sr_q      <= '0;
                bit_cnt_q <= '0;
                tmo_cnt_q <= '0;
            end else if (state_q == StShift) begin
                if (sin_valid) begin
                    bit_cnt_q <= bit_cnt_q + CntW'(1);
                    tmo_cnt_q <= '0;
                    if (bit_cnt_q < DataCnt) begin
                        sr_q <= sr_shift;
                    end
                end else if (tmo_cnt_q != TmoMax) begin
                    tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                end
            end
            if (last_bit && frame_ok) begin
                d_q <= word;
            end
        end
    end

    en_abort_excl: assert property (@(posedge clk) disable iff (rest) !(en && abort));
    en_single:     assert property (@(posedge clk) disable iff (rest) en |=> !en);

endmodule

// File: tb/tb_dreg_serial_loader.sv
// Self-checking bench for dreg_serial_loader: directed vector table, hand sequences,
// and randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps

module tb_dreg_serial_loader;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned MSB_FIRST = 1;
    localparam int unsigned TIMEOUT   = 15;
`ifdef PARITY_CHECK_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rest;
    logic             sin_valid;
    logic             sin_bit;
    logic [WIDTH-1:0] D_out;
    logic             en;
    logic             busy;
    logic             abort;
    logic             par_err;

    always #5 clk = ~clk;

    dreg_serial_loader #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rest      (rest),
        .sin_valid (sin_valid),
        .sin_bit   (sin_bit),
        .D_out     (D_out),
        .en        (en),
        .busy      (busy),
        .abort     (abort),
        .par_err   (par_err)
    );

    int checks = 0;
    int failures = 0;
    int en_cnt = 0;
    int abort_cnt = 0;
    int perr_cnt = 0;
    int overlap_cnt = 0;

    always @(negedge clk) begin
        if (!rest) begin
            en_cnt      += int'(en);
            abort_cnt   += int'(abort);
            perr_cnt    += int'(par_err);
            overlap_cnt += int'(en && abort);
        end
    end

    typedef struct {
        logic       v;
        logic       b;
        logic       en;
        logic       busy;
        logic       abort;
        logic [3:0] d;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic b, input logic e, input logic bz,
                                input logic ab, input logic [3:0] d);
        vec_t t;
        t = '{v, b, e, bz, ab, d};
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic b);
        sin_valid = v;
        sin_bit   = b;
        @(posedge clk);
        #1;
    endtask

    // Start bit, then nbits frame bits (data then parity), each preceded by a random gap.
    task automatic send_frame(input logic [3:0] data, input int nbits, input int gap_lo,
                              input int gap_hi, input logic flip);
        logic bv;
        step(1'b1, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            repeat ($urandom_range(gap_hi, gap_lo)) step(1'b0, 1'b0);
            if (i < int'(WIDTH)) begin
                bv = (MSB_FIRST != 0) ? data[WIDTH-1-i] : data[i];
            end else begin
                bv = (^data) ^ flip;
            end
            step(1'b1, bv);
        end
    endtask

    int e0, a0, p0;
    logic [3:0] model_d;

    initial begin
        rest = 1'b1;
        sin_valid = 1'b0;
        sin_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_d", D_out, 0);
        check("rst_en", en, 0);
        check("rst_busy", busy, 0);
        check("rst_abort", abort, 0);
        check("rst_perr", par_err, 0);
        rest = 1'b0;

        // Idle line, frame 1011, start in LOAD dropped, then frame 0001 with a gap.
        add(1, 1, 0, 0, 0, 4'b0000);
        add(1, 0, 0, 1, 0, 4'b0000);
        add(1, 1, 0, 1, 0, 4'b0000);
        add(1, 0, 0, 1, 0, 4'b0000);
        add(1, 1, 0, 1, 0, 4'b0000);
`ifdef PARITY_CHECK_EN
        add(1, 1, 0, 1, 0, 4'b0000);
        add(1, 1, 1, 1, 0, 4'b1011);
`else
        add(1, 1, 1, 1, 0, 4'b1011);
`endif
        add(1, 0, 0, 0, 0, 4'b1011);
        add(1, 0, 0, 1, 0, 4'b1011);
        add(1, 0, 0, 1, 0, 4'b1011);
        add(0, 1, 0, 1, 0, 4'b1011);
        add(1, 0, 0, 1, 0, 4'b1011);
        add(1, 0, 0, 1, 0, 4'b1011);
`ifdef PARITY_CHECK_EN
        add(1, 1, 0, 1, 0, 4'b1011);
        add(1, 1, 1, 1, 0, 4'b0001);
`else
        add(1, 1, 1, 1, 0, 4'b0001);
`endif
        add(0, 0, 0, 0, 0, 4'b0001);
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].b);
            check($sformatf("vec%0d_en", i), en, vecs[i].en);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_abort", i), abort, vecs[i].abort);
            check($sformatf("vec%0d_d", i), D_out, vecs[i].d);
        end

        // Frame with 3 idle cycles between bits.
        e0 = en_cnt; a0 = abort_cnt;
        send_frame(4'b1011, NB, 3, 3, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("gap_en_cnt", en_cnt - e0, 1);
        check("gap_abort_cnt", abort_cnt - a0, 0);
        check("gap_d", D_out, 4'b1011);

        // Timeout: two data bits, then TIMEOUT empty cycles.
        e0 = en_cnt; a0 = abort_cnt;
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        repeat (TIMEOUT - 1) step(1'b0, 1'b0);
        check("tmo_early_abort", abort, 0);
        check("tmo_early_busy", busy, 1);
        step(1'b0, 1'b0);
        check("tmo_abort", abort, 1);
        check("tmo_busy", busy, 0);
        check("tmo_en", en, 0);
        step(1'b0, 1'b0);
        check("tmo_abort_pulse", abort, 0);
        check("tmo_abort_cnt", abort_cnt - a0, 1);
        check("tmo_en_cnt", en_cnt - e0, 0);
        check("tmo_d", D_out, 4'b1011);

        // Asynchronous reset mid-frame.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        #2;
        rest = 1'b1;
        #1;
        check("mid_rst_d", D_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_en", en, 0);
        @(posedge clk);
        #1;
        rest = 1'b0;
        send_frame(4'b0110, NB, 0, 0, 1'b0);
        check("post_rst_en", en, 1);
        check("post_rst_d", D_out, 4'b0110);
        step(1'b0, 1'b0);
        model_d = 4'b0110;

`ifdef PARITY_CHECK_EN
        e0 = en_cnt; p0 = perr_cnt;
        send_frame(4'b1011, NB, 0, 0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("par_ok_en_cnt", en_cnt - e0, 1);
        check("par_ok_d", D_out, 4'b1011);
        check("par_ok_perr_cnt", perr_cnt - p0, 0);
        e0 = en_cnt; p0 = perr_cnt;
        send_frame(4'b0101, NB, 0, 0, 1'b1);
        check("par_bad_pulse", par_err, 1);
        check("par_bad_busy", busy, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("par_bad_perr_cnt", perr_cnt - p0, 1);
        check("par_bad_en_cnt", en_cnt - e0, 0);
        check("par_bad_d", D_out, 4'b1011);
        model_d = 4'b1011;
`endif

        // Random frames against a frame-level model: good frames load, aborted/bad ones don't.
        for (int f = 0; f < 80; f++) begin
            logic [3:0] data;
            int kind;
            int exp_en, exp_ab, exp_pe;
            repeat ($urandom_range(3, 0)) step(1'(($urandom_range(1, 0))), 1'b1);
            data = 4'($urandom_range(15, 0));
            kind = int'($urandom_range(9, 0));
            e0 = en_cnt; a0 = abort_cnt; p0 = perr_cnt;
            exp_en = 0; exp_ab = 0; exp_pe = 0;
            if (kind < 2) begin
                send_frame(data, int'($urandom_range(NB - 1, 0)), 0, 2, 1'b0);
                repeat (TIMEOUT) step(1'b0, 1'b0);
                exp_ab = 1;
            end else if (NB > int'(WIDTH) && kind == 2) begin
                send_frame(data, NB, 0, 2, 1'b1);
                exp_pe = 1;
            end else if (kind == 3) begin
                send_frame(data, NB, TIMEOUT - 1, TIMEOUT - 1, 1'b0);
                exp_en = 1;
                model_d = data;
            end else begin
                send_frame(data, NB, 0, 2, 1'b0);
                exp_en = 1;
                model_d = data;
            end
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            check($sformatf("rnd%0d_en_cnt", f), en_cnt - e0, exp_en);
            check($sformatf("rnd%0d_abort_cnt", f), abort_cnt - a0, exp_ab);
            check($sformatf("rnd%0d_perr_cnt", f), perr_cnt - p0, exp_pe);
            check($sformatf("rnd%0d_d", f), D_out, model_d);
        end

        check("en_abort_overlap", overlap_cnt, 0);
`ifndef PARITY_CHECK_EN
        check("perr_never", perr_cnt, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
